mont_exp_ctrl: RTL and testbench
================================

# mont_exp_ctrl

Left-to-right square-and-multiply controller that computes modular exponentiation by sequencing the 512-bit Montgomery multiplier (`montgomery`). It sits directly upstream of the multiplier: it latches base, exponent, modulus and R mod M, issues one start pulse per multiplication with operands on the multiplier's `in_a`/`in_b`/`in_m`, and captures the multiplier's `result` on its `done`. An optional final multiply-by-1 converts the result out of the Montgomery domain.

## Interface
- `DATA_W`, 512: operand width; must equal the multiplier width.
- `EXP_W`, 512: exponent width in bits, 2..1024.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high; top level drives the multiplier's `resetn` from `~reset`.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `in_x` in DATA_W: base, already in Montgomery domain (x·R mod M).
- `in_r` in DATA_W: R mod M (Montgomery one).
- `in_e` in EXP_W: exponent.
- `in_m` in DATA_W: odd modulus.
- `result` out DATA_W: registered exponentiation result.
- `done` out 1: one-cycle pulse when `result` is valid.
- `busy` out 1: high from the cycle after accepted `start` until the `done` cycle inclusive.
- `mm_start` out 1: one-cycle start pulse to the multiplier.
- `mm_in_a`, `mm_in_b`, `mm_in_m` out DATA_W: multiplier operands, registered, stable from the `mm_start` cycle until `mm_done`.
- `mm_result` in DATA_W: multiplier result.
- `mm_done` in 1: multiplier completion pulse.

## Operation
- Registers: A (accumulator), X, M, E (shift-left exponent), bit counter `cnt` of `$clog2(EXP_W+1)` bits.
- States: IDLE, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, CONV_ISSUE, CONV_WAIT, DONE.
- IDLE: on `start`, load A←`in_r`, X←`in_x`, M←`in_m`, E←`in_e`, cnt←EXP_W; go to SQ_ISSUE.
- SQ_ISSUE: `mm_start`=1, operands (A, A, M); go to SQ_WAIT.
- SQ_WAIT: on `mm_done`, A←`mm_result`. If E[EXP_W-1]=1, go to MUL_ISSUE. Otherwise shift E left, decrement cnt, and go to SQ_ISSUE; when cnt reaches 0, go to CONV_ISSUE instead (DONE if the macro is off).
- MUL_ISSUE: `mm_start`=1, operands (A, X, M); go to MUL_WAIT.
- MUL_WAIT: on `mm_done`, A←`mm_result`, shift E, decrement cnt; next state follows the same rule as SQ_WAIT.
- CONV_ISSUE/CONV_WAIT: operands (A, 1, M); on `mm_done`, A←`mm_result`; go to DONE.
- DONE: `result`←A, `done`=1 for one cycle, return to IDLE.
- Leading exponent zeros are harmless: squaring R mod M gives R mod M.
- Multiplication count is EXP_W + popcount(`in_e`) (+1 with conversion).

## Timing
- Reset values: `result`=0, `done`=0, `busy`=0, `mm_start`=0, `mm_in_*`=0, state=IDLE.
- Each multiply costs 1 issue cycle plus Lmm cycles, where Lmm is the number of cycles from `mm_start` to `mm_done`. The state advances on the `mm_done` edge.
- `done` asserts one cycle after the final `mm_done`. `result` holds until the next `done`.
- `start` while busy is ignored, with no queueing.
- `mm_done` outside a WAIT state is ignored.
- `in_*` are sampled only in the `start` cycle; they may change afterwards.
- Reset mid-operation: state returns to IDLE immediately (asynchronous). The multiplier is reset by the same source, and no `done` is produced.
- E=0: result = conversion of R mod M, i.e. 1 (or `in_r` without conversion).

## Configuration
- `MONTEXP_FINAL_CONVERT_EN` defined: CONV states are present, and `result` is x^e mod M in the normal domain.
- Undefined: CONV states are removed, the last WAIT state goes directly to DONE, and `result` is x^e·R mod M (Montgomery domain).

## Test plan
Bench uses a behavioural multiplier model that returns a·b·R⁻¹ mod M, with Lmm=10 and R=2^512.
- `EXP_W`=8, `in_e`=8'hA5, conversion on → exactly 13 `mm_start` pulses (8 squares, 4 multiplies, 1 conversion); `result` = x^165 mod M.
- `in_e`=0, conversion on → `result`=1; conversion off → `result`=`in_r`.
- `in_e`=1, M=2^511+187, x=3 (in Montgomery form), conversion on → `result`=3. `done` arrives after 8·11 + 1·11 + 11 + 1 cycles.
- `start` pulsed again mid-run → ignored; total `mm_start` count unchanged; a single `done`.
- `reset` asserted during MUL_WAIT → next cycle state is IDLE, `busy`=0, `done`=0, `result`=0. A fresh `start` then completes correctly.
- Spurious `mm_done` in IDLE, and during ISSUE states → no state change and A unchanged.

Source files
------------

// File: rtl/mont_exp_ctrl.sv
// rtl/mont_exp_ctrl.sv - left-to-right square-and-multiply controller sequencing a Montgomery multiplier
// Optional final multiply-by-1 out of the Montgomery domain: define MONTEXP_FINAL_CONVERT_EN.
module mont_exp_ctrl #(
  parameter int DATA_W = 512,
  parameter int EXP_W  = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_r,
  input  logic [EXP_W-1:0]  in_e,
  input  logic [DATA_W-1:0] in_m,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic              busy,
  output logic              mm_start,
  output logic [DATA_W-1:0] mm_in_a,
  output logic [DATA_W-1:0] mm_in_b,
  output logic [DATA_W-1:0] mm_in_m,
  input  logic [DATA_W-1:0] mm_result,
  input  logic              mm_done
);

  localparam int                CNT_W    = $clog2(EXP_W + 1);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(EXP_W);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
`ifdef MONTEXP_FINAL_CONVERT_EN
  localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQ_ISSUE,
    S_SQ_WAIT,
    S_MUL_ISSUE,
    S_MUL_WAIT,
`ifdef MONTEXP_FINAL_CONVERT_EN
    S_CONV_ISSUE,
    S_CONV_WAIT,
`endif
    S_DONE
  } state_t;

  state_t            state_q;
  // a_q is the accumulator and doubles as the multiplier's A operand register
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] x_q;
  logic [DATA_W-1:0] m_q;
  logic [DATA_W-1:0] result_q;
  logic [EXP_W-1:0]  e_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              done_q;
  logic              busy_q;
  logic              mm_start_q;

  logic [EXP_W-1:0]  e_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              last_d;

  // Exponent walk: next shifted exponent, next bit count, and whether this was the last bit
  assign e_d    = e_q << 1;
  assign cnt_d  = cnt_q - CNT_ONE;
  assign last_d = (cnt_d == '0);

  assign result   = result_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign mm_start = mm_start_q;
  assign mm_in_a  = a_q;
  assign mm_in_b  = b_q;
  assign mm_in_m  = m_q;

  // Sequencer: operands and start pulse are registered on entry to each ISSUE state,
  // so they are stable from the mm_start cycle until the matching mm_done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      x_q        <= '0;
      m_q        <= '0;
      result_q   <= '0;
      e_q        <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      mm_start_q <= 1'b0;
    end else begin
      mm_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q        <= in_r;
            b_q        <= in_r;
            x_q        <= in_x;
            m_q        <= in_m;
            e_q        <= in_e;
            cnt_q      <= CNT_INIT;
            busy_q     <= 1'b1;
            mm_start_q <= 1'b1;
            state_q    <= S_SQ_ISSUE;
          end
        end
        S_SQ_ISSUE:  state_q <= S_SQ_WAIT;
        S_MUL_ISSUE: state_q <= S_MUL_WAIT;
        S_SQ_WAIT, S_MUL_WAIT: begin
          if (mm_done) begin
            a_q <= mm_result;
            if ((state_q == S_SQ_WAIT) && e_q[EXP_W-1]) begin
              // current bit is 1: multiply by the base before moving on
              b_q        <= x_q;
              mm_start_q <= 1'b1;
              state_q    <= S_MUL_ISSUE;
            end else begin
              e_q   <= e_d;
              cnt_q <= cnt_d;
              if (!last_d) begin
                b_q        <= mm_result;
                mm_start_q <= 1'b1;
                state_q    <= S_SQ_ISSUE;
              end else begin
`ifdef MONTEXP_FINAL_CONVERT_EN
                b_q        <= ONE;
                mm_start_q <= 1'b1;
                state_q    <= S_CONV_ISSUE;
`else
                result_q   <= mm_result;
                done_q     <= 1'b1;
                state_q    <= S_DONE;
`endif
              end
            end
          end
        end
`ifdef MONTEXP_FINAL_CONVERT_EN
        S_CONV_ISSUE: state_q <= S_CONV_WAIT;
        S_CONV_WAIT: begin
          if (mm_done) begin
            a_q      <= mm_result;
            result_q <= mm_result;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// tb/tb_mont_exp_ctrl.sv - self-checking bench for mont_exp_ctrl with a behavioural Montgomery multiplier
module tb_mont_exp_ctrl;

  localparam int DW  = 512;
  localparam int EW  = 8;
  localparam int LMM = 10;
`ifdef MONTEXP_FINAL_CONVERT_EN
  localparam int CONV = 1;
`else
  localparam int CONV = 0;
`endif

  logic          clk;
  logic          reset;
  logic          start;
  logic [DW-1:0] in_x;
  logic [DW-1:0] in_r;
  logic [EW-1:0] in_e;
  logic [DW-1:0] in_m;
  logic [DW-1:0] result;
  logic          done;
  logic          busy;
  logic          mm_start;
  logic [DW-1:0] mm_in_a;
  logic [DW-1:0] mm_in_b;
  logic [DW-1:0] mm_in_m;
  logic [DW-1:0] mm_result;
  logic          mm_done;

  int n_vec;
  int n_err;
  int spur_req;
  int spur_ack;
  int mm_start_cnt;
  int done_cnt;

  logic [DW-1:0] obs_res;
  logic [DW-1:0] obs_res_hold;
  logic [DW-1:0] obs_a_c2;
  int            obs_lat;
  int            obs_nmm;
  int            obs_ndone;
  logic          obs_busy1;
  logic          obs_busy_done;
  logic          obs_busy_after;

  mont_exp_ctrl #(.DATA_W(DW), .EXP_W(EW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_x      (in_x),
    .in_r      (in_r),
    .in_e      (in_e),
    .in_m      (in_m),
    .result    (result),
    .done      (done),
    .busy      (busy),
    .mm_start  (mm_start),
    .mm_in_a   (mm_in_a),
    .mm_in_b   (mm_in_b),
    .mm_in_m   (mm_in_m),
    .mm_result (mm_result),
    .mm_done   (mm_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [DW-1:0] rand512();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [DW-1:0] rand_mod();
    logic [DW-1:0] v;
    v = rand512();
    v[DW-1] = 1'b1;
    v[0] = 1'b1;
    return v;
  endfunction

  // a*b*2^-512 mod m, used only to answer the DUT's multiply requests
  function automatic logic [DW-1:0] mont_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [DW-1:0] m);
    logic [2*DW+1:0] t;
    logic [2*DW+1:0] mm;
    mm = {514'd0, m};
    t = {514'd0, a} * {514'd0, b};
    for (int i = 0; i < DW; i++) begin
      if (t[0]) t = t + mm;
      t = t >> 1;
    end
    if (t >= mm) t = t - mm;
    return t[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] mulmod(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] m);
    logic [2*DW-1:0] t;
    t = ({512'd0, a} * {512'd0, b}) % {512'd0, m};
    return t[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] to_mont(input logic [DW-1:0] x, input logic [DW-1:0] m);
    logic [2*DW-1:0] t;
    t = {x, 512'd0} % {512'd0, m};
    return t[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] r_mod(input logic [DW-1:0] m);
    logic [2*DW-1:0] t;
    logic [2*DW-1:0] one;
    one = 1024'd1;
    t = (one << DW) % {512'd0, m};
    return t[DW-1:0];
  endfunction

  // plain right-to-left exponentiation in the normal domain
  function automatic logic [DW-1:0] ref_modexp(input logic [DW-1:0] x, input logic [EW-1:0] e,
                                               input logic [DW-1:0] m);
    logic [DW-1:0] acc;
    logic [DW-1:0] base;
    acc = 512'd1;
    base = x % m;
    for (int i = 0; i < EW; i++) begin
      if (e[i]) acc = mulmod(acc, base, m);
      base = mulmod(base, base, m);
    end
    return acc;
  endfunction

  function automatic logic [DW-1:0] ref_result(input logic [DW-1:0] x, input logic [EW-1:0] e,
                                               input logic [DW-1:0] m);
    logic [DW-1:0] p;
    p = ref_modexp(x, e, m);
    return (CONV != 0) ? p : mulmod(p, r_mod(m), m);
  endfunction

  function automatic int exp_nmul(input logic [EW-1:0] e);
    return EW + $countones(e) + CONV;
  endfunction

  // Behavioural multiplier: answers each mm_start with mm_done LMM cycles later
  initial begin
    logic [DW-1:0] pres;
    bit            pend;
    int            cd;
    mm_done = 1'b0;
    mm_result = '0;
    mm_start_cnt = 0;
    spur_ack = 0;
    pend = 1'b0;
    cd = 0;
    pres = '0;
    forever begin
      @(negedge clk);
      mm_done = 1'b0;
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          cd--;
          if (cd == 0) begin
            mm_done = 1'b1;
            mm_result = pres;
            pend = 1'b0;
          end
        end
        if (spur_req != spur_ack) begin
          spur_ack = spur_req;
          mm_done = 1'b1;
          mm_result = ~mm_result;
        end
        if (mm_start) begin
          mm_start_cnt++;
          pend = 1'b1;
          cd = LMM;
          pres = mont_mul(mm_in_a, mm_in_b, mm_in_m);
        end
      end
    end
  end

  initial begin
    done_cnt = 0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic run_op(input logic [DW-1:0] xm, input logic [DW-1:0] r, input logic [DW-1:0] m,
                        input logic [EW-1:0] e, input bit poke_start, input bit poke_spur);
    int s0;
    int d0;
    @(negedge clk);
    s0 = mm_start_cnt;
    d0 = done_cnt;
    in_x = xm;
    in_r = r;
    in_m = m;
    in_e = e;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (poke_spur) spur_req++;
    @(negedge clk);
    start = 1'b0;
    obs_busy1 = busy;
    in_x = rand512();
    in_r = rand512();
    in_m = rand512();
    in_e = 8'($urandom);
    obs_lat = 1;
    obs_a_c2 = '0;
    while (done !== 1'b1 && obs_lat < 2000) begin
      if (obs_lat == 2) obs_a_c2 = mm_in_a;
      start = poke_start && (obs_lat == 30);
      @(negedge clk);
      obs_lat++;
    end
    start = 1'b0;
    obs_res = result;
    obs_busy_done = busy;
    repeat (3) @(negedge clk);
    obs_res_hold = result;
    obs_busy_after = busy;
    obs_nmm = mm_start_cnt - s0;
    obs_ndone = done_cnt - d0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (result !== '0) begin n_err++; $display("FAIL reset_result: got %h expected 0", result); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (mm_start !== 1'b0) begin n_err++; $display("FAIL reset_mm_start: got %b expected 0", mm_start); end
    n_vec++; if ((mm_in_a | mm_in_b | mm_in_m) !== '0) begin n_err++; $display("FAIL reset_operands: a %h b %h m %h expected 0", mm_in_a, mm_in_b, mm_in_m); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b0 || done_cnt != 0) begin n_err++; $display("FAIL post_reset_idle: busy %b dones %0d expected 0/0", busy, done_cnt); end
  endtask

  task automatic test_e_a5();
    logic [DW-1:0] m;
    logic [DW-1:0] x;
    logic [DW-1:0] expv;
    m = rand_mod();
    x = rand512() % m;
    expv = ref_result(x, 8'hA5, m);
    run_op(to_mont(x, m), r_mod(m), m, 8'hA5, 1'b0, 1'b0);
    n_vec++; if (obs_res !== expv) begin n_err++; $display("FAIL a5_result: got %h expected %h", obs_res, expv); end
    n_vec++; if (obs_nmm != 12 + CONV) begin n_err++; $display("FAIL a5_mm_starts: got %0d expected %0d", obs_nmm, 12 + CONV); end
    n_vec++; if (obs_ndone != 1) begin n_err++; $display("FAIL a5_done_count: got %0d expected 1", obs_ndone); end
    n_vec++; if (obs_busy1 !== 1'b1) begin n_err++; $display("FAIL a5_busy_first: got %b expected 1", obs_busy1); end
    n_vec++; if (obs_busy_done !== 1'b1) begin n_err++; $display("FAIL a5_busy_done: got %b expected 1", obs_busy_done); end
    n_vec++; if (obs_busy_after !== 1'b0) begin n_err++; $display("FAIL a5_busy_after: got %b expected 0", obs_busy_after); end
    n_vec++; if (obs_res_hold !== expv) begin n_err++; $display("FAIL a5_result_hold: got %h expected %h", obs_res_hold, expv); end
    n_vec++; if (obs_lat != (12 + CONV) * (LMM + 1) + 1) begin n_err++; $display("FAIL a5_latency: got %0d expected %0d", obs_lat, (12 + CONV) * (LMM + 1) + 1); end
  endtask

  task automatic test_e_zero();
    logic [DW-1:0] m;
    logic [DW-1:0] r;
    logic [DW-1:0] expv;
    m = rand_mod();
    r = r_mod(m);
    expv = (CONV != 0) ? 512'd1 : r;
    run_op(to_mont(rand512() % m, m), r, m, 8'h00, 1'b0, 1'b0);
    n_vec++; if (obs_res !== expv) begin n_err++; $display("FAIL e0_result: got %h expected %h", obs_res, expv); end
    n_vec++; if (obs_nmm != 8 + CONV) begin n_err++; $display("FAIL e0_mm_starts: got %0d expected %0d", obs_nmm, 8 + CONV); end
  endtask

  task automatic test_e_one();
    logic [DW-1:0] m;
    logic [DW-1:0] expv;
    m = '0;
    m[DW-1] = 1'b1;
    m[7:0] = 8'd187;
    expv = (CONV != 0) ? 512'd3 : to_mont(512'd3, m);
    run_op(to_mont(512'd3, m), r_mod(m), m, 8'h01, 1'b0, 1'b0);
    n_vec++; if (obs_res !== expv) begin n_err++; $display("FAIL e1_result: got %h expected %h", obs_res, expv); end
    n_vec++; if (obs_lat != 8 * (LMM + 1) + (LMM + 1) + CONV * (LMM + 1) + 1) begin n_err++; $display("FAIL e1_latency: got %0d expected %0d", obs_lat, 9 * (LMM + 1) + CONV * (LMM + 1) + 1); end
  endtask

  task automatic test_random();
    logic [DW-1:0] m;
    logic [DW-1:0] x;
    logic [EW-1:0] e;
    logic [DW-1:0] expv;
    for (int i = 0; i < 4; i++) begin
      m = rand_mod();
      x = rand512() % m;
      e = 8'($urandom);
      if (i == 0) e = 8'hFF;
      expv = ref_result(x, e, m);
      run_op(to_mont(x, m), r_mod(m), m, e, 1'b0, 1'b0);
      n_vec++; if (obs_res !== expv) begin n_err++; $display("FAIL rand%0d_result e=%h: got %h expected %h", i, e, obs_res, expv); end
      n_vec++; if (obs_nmm != exp_nmul(e)) begin n_err++; $display("FAIL rand%0d_mm_starts: got %0d expected %0d", i, obs_nmm, exp_nmul(e)); end
      n_vec++; if (obs_lat != exp_nmul(e) * (LMM + 1) + 1) begin n_err++; $display("FAIL rand%0d_latency: got %0d expected %0d", i, obs_lat, exp_nmul(e) * (LMM + 1) + 1); end
    end
  endtask

  task automatic test_back_to_back_start();
    logic [DW-1:0] m;
    logic [DW-1:0] x;
    logic [EW-1:0] e;
    logic [DW-1:0] expv;
    m = rand_mod();
    x = rand512() % m;
    e = 8'($urandom) | 8'h80;
    expv = ref_result(x, e, m);
    run_op(to_mont(x, m), r_mod(m), m, e, 1'b1, 1'b0);
    n_vec++; if (obs_res !== expv) begin n_err++; $display("FAIL restart_result: got %h expected %h", obs_res, expv); end
    n_vec++; if (obs_nmm != exp_nmul(e)) begin n_err++; $display("FAIL restart_mm_starts: got %0d expected %0d", obs_nmm, exp_nmul(e)); end
    n_vec++; if (obs_ndone != 1) begin n_err++; $display("FAIL restart_done_count: got %0d expected 1", obs_ndone); end
  endtask

  task automatic test_spurious();
    logic [DW-1:0] a0;
    logic [DW-1:0] m;
    logic [DW-1:0] x;
    logic [DW-1:0] r;
    logic [EW-1:0] e;
    logic [DW-1:0] expv;
    int            d0;
    @(negedge clk);
    a0 = mm_in_a;
    d0 = done_cnt;
    spur_req++;
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b0 || mm_start !== 1'b0) begin n_err++; $display("FAIL spur_idle_state: busy %b mm_start %b expected 0/0", busy, mm_start); end
    n_vec++; if (mm_in_a !== a0) begin n_err++; $display("FAIL spur_idle_acc: got %h expected %h", mm_in_a, a0); end
    n_vec++; if (done_cnt != d0) begin n_err++; $display("FAIL spur_idle_done: got %0d dones expected 0", done_cnt - d0); end
    m = rand_mod();
    x = rand512() % m;
    r = r_mod(m);
    e = 8'($urandom);
    expv = ref_result(x, e, m);
    run_op(to_mont(x, m), r, m, e, 1'b0, 1'b1);
    n_vec++; if (obs_a_c2 !== r) begin n_err++; $display("FAIL spur_issue_acc: got %h expected %h", obs_a_c2, r); end
    n_vec++; if (obs_res !== expv) begin n_err++; $display("FAIL spur_issue_result: got %h expected %h", obs_res, expv); end
    n_vec++; if (obs_lat != exp_nmul(e) * (LMM + 1) + 1) begin n_err++; $display("FAIL spur_issue_latency: got %0d expected %0d", obs_lat, exp_nmul(e) * (LMM + 1) + 1); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] m;
    logic [DW-1:0] x;
    logic [DW-1:0] xm;
    logic [EW-1:0] e;
    logic [DW-1:0] expv;
    int            d0;
    m = rand_mod();
    x = rand512() % m;
    xm = to_mont(x, m);
    @(negedge clk);
    d0 = done_cnt;
    in_x = xm;
    in_r = r_mod(m);
    in_m = m;
    in_e = 8'h80;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    n_vec++; if (mm_in_b !== xm || busy !== 1'b1) begin n_err++; $display("FAIL rmid_in_mul: b %h busy %b expected %h/1", mm_in_b, busy, xm); end
    reset = 1'b1;
    #1;
    n_vec++; if (busy !== 1'b0 || done !== 1'b0 || mm_start !== 1'b0) begin n_err++; $display("FAIL rmid_ctrl: busy %b done %b mm_start %b expected 0/0/0", busy, done, mm_start); end
    n_vec++; if (result !== '0 || mm_in_a !== '0) begin n_err++; $display("FAIL rmid_regs: result %h a %h expected 0", result, mm_in_a); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    n_vec++; if (done_cnt != d0 || busy !== 1'b0) begin n_err++; $display("FAIL rmid_no_done: dones %0d busy %b expected 0/0", done_cnt - d0, busy); end
    e = 8'($urandom);
    expv = ref_result(x, e, m);
    run_op(xm, r_mod(m), m, e, 1'b0, 1'b0);
    n_vec++; if (obs_res !== expv) begin n_err++; $display("FAIL rmid_fresh_result: got %h expected %h", obs_res, expv); end
    n_vec++; if (obs_nmm != exp_nmul(e)) begin n_err++; $display("FAIL rmid_fresh_mm_starts: got %0d expected %0d", obs_nmm, exp_nmul(e)); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    spur_req = 0;
    reset = 1'b1;
    start = 1'b0;
    in_x = '0;
    in_r = '0;
    in_e = '0;
    in_m = '0;
    test_reset();
    test_e_a5();
    test_e_zero();
    test_e_one();
    test_random();
    test_back_to_back_start();
    test_spurious();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
